// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with branch/jump redirect, stall and multi-cycle flush.
// Optional PC_REDIRECT_PERF_EN adds taken-branch and flush-cycle counters.
module pc_redirect_unit #(
    parameter int          PC_W      = 32,
    parameter int          IMM_W     = 16,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          FLUSH_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            fetch_ready_i,
    input  logic            br_valid_i,
    input  logic            br_taken_i,
    input  logic [PC_W-1:0] br_pc_i,
    input  logic [IMM_W-1:0] br_imm_i,
    input  logic            jmp_valid_i,
    input  logic [PC_W-1:0] jmp_target_i,
    output logic [PC_W-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            flush_o,
    output logic            misalign_o
`ifdef PC_REDIRECT_PERF_EN
    ,
    output logic [31:0]     br_taken_cnt_o,
    output logic [31:0]     flush_cnt_o
`endif
);
    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_VEC);
    localparam int CW = FLUSH_CYC > 1 ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t          state_q;
    logic [PC_W-1:0] pc_q, pc_d, br_tgt, jmp_tgt;
    logic            pc_valid_q, flush_q, misalign_q, misalign_d;
    logic [CW-1:0]   cnt_q;
    logic            br_take, redir, adv;

    assign br_take = br_valid_i & br_taken_i;
    assign redir   = (state_q != BOOT) & (br_take | jmp_valid_i);
    assign br_tgt  = br_pc_i + PC_W'(4) + (PC_W'($signed(br_imm_i)) << 2);
    assign jmp_tgt = {jmp_target_i[PC_W-1:2], 2'b00};
    assign adv     = (state_q == RUN) & pc_valid_q & fetch_ready_i & ~stall_i;
    // A taken branch is older than a same-cycle jump, so it wins the redirect.
    assign pc_d       = redir ? (br_take ? br_tgt : jmp_tgt) : adv ? pc_q + PC_W'(4) : pc_q;
    assign misalign_d = redir & ~br_take & (|jmp_target_i[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RST_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            if (state_q == BOOT) begin
                state_q    <= RUN;
                pc_valid_q <= 1'b1;
            end else if (redir) begin
                state_q    <= FLUSH;
                flush_q    <= 1'b1;
                pc_valid_q <= 1'b0;
                cnt_q      <= CW'(FLUSH_CYC - 1);
            end else if (state_q == FLUSH) begin
                if (cnt_q == '0) begin
                    state_q    <= RUN;
                    flush_q    <= 1'b0;
                    pc_valid_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = pc_valid_q;
    assign flush_o    = flush_q;
    assign misalign_o = misalign_q;

`ifdef PC_REDIRECT_PERF_EN
    logic [31:0] br_taken_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken_cnt_q <= '0;
            flush_cnt_q    <= '0;
        end else begin
            if (br_take && state_q != BOOT && br_taken_cnt_q != '1)
                br_taken_cnt_q <= br_taken_cnt_q + 32'd1;
            if (flush_q && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign br_taken_cnt_o = br_taken_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed checks of PC sequencing, stall, redirect and flush (FLUSH_CYC=3).
module tb_pc_redirect_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0, fetch_ready_i = 1'b1;
    logic        br_valid_i = 1'b0, br_taken_i = 1'b0, jmp_valid_i = 1'b0;
    logic [31:0] br_pc_i = '0, jmp_target_i = '0;
    logic [15:0] br_imm_i = '0;
    logic [31:0] pc_o;
    logic        pc_valid_o, flush_o, misalign_o;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    pc_redirect_unit #(.FLUSH_CYC(3)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
        .br_valid_i(br_valid_i), .br_taken_i(br_taken_i), .br_pc_i(br_pc_i), .br_imm_i(br_imm_i),
        .jmp_valid_i(jmp_valid_i), .jmp_target_i(jmp_target_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o), .flush_o(flush_o), .misalign_o(misalign_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        br_valid_i = 1'b0; br_taken_i = 1'b0; jmp_valid_i = 1'b0; stall_i = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_valid", {31'b0, pc_valid_o}, 32'd0);
        chk("rst_flush", {31'b0, flush_o}, 32'd0);
        chk("rst_mis", {31'b0, misalign_o}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        #2;
        chk("boot_valid", {31'b0, pc_valid_o}, 32'd0);
        step();
        chk("run_pc0", pc_o, 32'h0);
        chk("run_valid", {31'b0, pc_valid_o}, 32'd1);
        step();
        chk("seq_pc4", pc_o, 32'h4);
        step();
        chk("seq_pc8", pc_o, 32'h8);
        repeat (62) step();
        chk("seq_pc100", pc_o, 32'h100);
        // not-taken branch has no effect
        br_valid_i = 1'b1; br_taken_i = 1'b0; br_pc_i = 32'h100; br_imm_i = 16'h0040;
        step();
        idle();
        chk("nt_pc", pc_o, 32'h104);
        chk("nt_flush", {31'b0, flush_o}, 32'd0);
        // go back to 0x100 via taken branch with imm -1 (target = pc+4-4)
        br_valid_i = 1'b1; br_taken_i = 1'b1; br_pc_i = 32'h100; br_imm_i = 16'hFFFF;
        stall_i = 1'b1;
        step();
        idle();
        chk("br_pc", pc_o, 32'h100);
        chk("br_flush0", {31'b0, flush_o}, 32'd1);
        chk("br_valid0", {31'b0, pc_valid_o}, 32'd0);
        step();
        chk("br_flush1", {31'b0, flush_o}, 32'd1);
        step();
        chk("br_flush2", {31'b0, flush_o}, 32'd1);
        step();
        chk("br_flush3", {31'b0, flush_o}, 32'd0);
        chk("br_valid3", {31'b0, pc_valid_o}, 32'd1);
        chk("br_pc3", pc_o, 32'h100);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", pc_o, 32'h100);
        end
        stall_i = 1'b0; fetch_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nordy_hold", pc_o, 32'h100);
        end
        fetch_ready_i = 1'b1;
        step();
        chk("br_adv", pc_o, 32'h104);
        // taken branch beats same-cycle jump
        br_valid_i = 1'b1; br_taken_i = 1'b1; br_pc_i = 32'h1F0; br_imm_i = 16'h0003;
        jmp_valid_i = 1'b1; jmp_target_i = 32'h401;
        step();
        idle();
        chk("bj_pc", pc_o, 32'h200);
        chk("bj_mis", {31'b0, misalign_o}, 32'd0);
        repeat (3) step();
        chk("bj_valid", {31'b0, pc_valid_o}, 32'd1);
        chk("bj_pc_end", pc_o, 32'h200);
        // misaligned jump, then a second redirect in flush cycle 2
        jmp_valid_i = 1'b1; jmp_target_i = 32'h203;
        step();
        idle();
        chk("mj_pc", pc_o, 32'h200);
        chk("mj_mis", {31'b0, misalign_o}, 32'd1);
        chk("mj_flush", {31'b0, flush_o}, 32'd1);
        step();
        chk("mj_mis_pulse", {31'b0, misalign_o}, 32'd0);
        jmp_valid_i = 1'b1; jmp_target_i = 32'h300;
        step();
        idle();
        chk("rj_pc", pc_o, 32'h300);
        chk("rj_flush0", {31'b0, flush_o}, 32'd1);
        step();
        chk("rj_flush1", {31'b0, flush_o}, 32'd1);
        step();
        chk("rj_flush2", {31'b0, flush_o}, 32'd1);
        step();
        chk("rj_flush3", {31'b0, flush_o}, 32'd0);
        chk("rj_valid", {31'b0, pc_valid_o}, 32'd1);
        step();
        chk("rj_adv", pc_o, 32'h304);
        // PC wrap at top of address space
        jmp_valid_i = 1'b1; jmp_target_i = 32'hFFFF_FFFC;
        step();
        idle();
        chk("wr_pc", pc_o, 32'hFFFF_FFFC);
        repeat (3) step();
        step();
        chk("wr_wrap", pc_o, 32'h0);
        // branch target arithmetic wraps too
        br_valid_i = 1'b1; br_taken_i = 1'b1; br_pc_i = 32'hFFFF_FFF8; br_imm_i = 16'h0001;
        step();
        idle();
        chk("bw_pc", pc_o, 32'h0);
        // async reset in the middle of a flush
        jmp_valid_i = 1'b1; jmp_target_i = 32'h502;
        step();
        idle();
        chk("pre_rst_mis", {31'b0, misalign_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_pc", pc_o, 32'h0);
        chk("ar_flush", {31'b0, flush_o}, 32'd0);
        chk("ar_valid", {31'b0, pc_valid_o}, 32'd0);
        chk("ar_mis", {31'b0, misalign_o}, 32'd0);
        step();
        rst_n = 1'b1;
        // redirect presented while in BOOT is ignored
        jmp_valid_i = 1'b1; jmp_target_i = 32'h700;
        step();
        idle();
        chk("boot_ign_pc", pc_o, 32'h0);
        chk("boot_ign_flush", {31'b0, flush_o}, 32'd0);
        step();
        chk("boot_ign_adv", pc_o, 32'h4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
